// File: rtl/xregbank_pkg.sv
// xregbank_pkg -- shared constants and types for the architectural register bank.
//   zero_word : all-zero data word (sliced down to the bank's data width; widths up to 64 bits)
//   reg0_addr : the hardwired-zero register address (sliced down to the address width)
//   dump_state_e : dump sequencer state encoding (idle / run)
package xregbank_pkg;

  localparam logic [63:0] zero_word = 64'h0;
  localparam logic [15:0] reg0_addr = 16'h0;

  typedef enum logic {
    dump_idle = 1'b0,
    dump_run  = 1'b1
  } dump_state_e;

endpackage

// File: rtl/xregbank_if.sv
// xregbank_if -- write port and dump handshake of the register bank.
//   master : the side that writes registers and consumes the dump stream
//   slave  : the register bank itself
//   we/waddr/wdata            : synchronous write port
//   dump_start/dump_ready     : dump request and per-entry acceptance
//   dump_busy/dump_valid      : sequencer activity and entry-presented flag
//   dump_addr/dump_data       : index and value of the presented entry
interface xregbank_if #(
  parameter int width  = 5,
  parameter int height = 32
);

  logic              we;
  logic [width-1:0]  waddr;
  logic [height-1:0] wdata;
  logic              dump_start;
  logic              dump_busy;
  logic              dump_valid;
  logic              dump_ready;
  logic [width-1:0]  dump_addr;
  logic [height-1:0] dump_data;

  modport master (
    output we, waddr, wdata, dump_start, dump_ready,
    input  dump_busy, dump_valid, dump_addr, dump_data
  );

  modport slave (
    input  we, waddr, wdata, dump_start, dump_ready,
    output dump_busy, dump_valid, dump_addr, dump_data
  );

endinterface

// File: rtl/xregbank_dump.sv
// xregbank_dump -- streams every register of the bank out in address order.
//   clk, rst_n            : clock, asynchronous active-low reset
//   regs_flat             : bit-sliced register bus (bit i*(1<<width)+r = bit i of reg r)
//   we, waddr, wdata      : bank write port, observed for same-edge bypass on load
//   dump_start            : one-cycle start request, honoured only when idle
//   dump_ready            : consumer accepts the presented entry
//   dump_busy, dump_valid : high for the whole run
//   dump_addr, dump_data  : presented entry, held stable until accepted
module xregbank_dump
  import xregbank_pkg::*;
#(
  parameter int width  = 5,
  parameter int height = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [(1<<width)*height-1:0] regs_flat,
  input  logic                         we,
  input  logic [width-1:0]             waddr,
  input  logic [height-1:0]            wdata,
  input  logic                         dump_start,
  input  logic                         dump_ready,
  output logic                         dump_busy,
  output logic                         dump_valid,
  output logic [width-1:0]             dump_addr,
  output logic [height-1:0]            dump_data
);

  localparam int nregs = 1 << width;
  localparam logic [width-1:0] zero_addr = {width{1'b0}};
  localparam logic [width-1:0] one_addr  = {{(width-1){1'b0}}, 1'b1};
  localparam logic [width-1:0] last_addr = {width{1'b1}};

  dump_state_e                   state_r, state_s;
  logic [width-1:0]              ptr_r, ptr_s, load_addr_s;
  logic [height-1:0]             data_r, sliced_s, pick_s;
  logic                          load_s, clear_s, bypass_s;
  logic [nregs-1:0][height-1:0]  word_s;

  // Regroup the bit-sliced bus into whole words so one index picks a register.
  for (genvar r = 0; r < nregs; r++) begin : g_word
    for (genvar i = 0; i < height; i++) begin : g_bit
      assign word_s[r][i] = regs_flat[i*nregs + r];
    end
  end

  // Value to load: the stored word, or wdata when the same edge writes that register.
  always_comb begin
    sliced_s = word_s[load_addr_s];
    bypass_s = we && (waddr == load_addr_s) && (waddr != reg0_addr[width-1:0]);
    pick_s   = bypass_s ? wdata : sliced_s;
  end

  // Dump FSM next-state, pointer advance and load/clear strobes.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    load_addr_s = ptr_r;
    load_s      = 1'b0;
    clear_s     = 1'b0;
    case (state_r)
      dump_idle: begin
        if (dump_start) begin
          state_s     = dump_run;
          ptr_s       = zero_addr;
          load_addr_s = zero_addr;
          load_s      = 1'b1;
        end else begin
          state_s = dump_idle;
        end
      end
      dump_run: begin
        if (dump_ready) begin
          if (ptr_r == last_addr) begin
            // last entry accepted: no wrap, the run ends here
            state_s = dump_idle;
            ptr_s   = zero_addr;
            clear_s = 1'b1;
          end else begin
            ptr_s       = ptr_r + one_addr;
            load_addr_s = ptr_r + one_addr;
            load_s      = 1'b1;
          end
        end else begin
          state_s = dump_run;
        end
      end
      default: begin
        state_s = dump_idle;
        ptr_s   = zero_addr;
        clear_s = 1'b1;
      end
    endcase
  end

  // State, pointer and output holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= dump_idle;
      ptr_r   <= zero_addr;
      data_r  <= zero_word[height-1:0];
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      if (load_s) begin
        data_r <= pick_s;
      end else if (clear_s) begin
        data_r <= zero_word[height-1:0];
      end
    end
  end

  assign dump_valid = (state_r == dump_run);
  assign dump_busy  = (state_r == dump_run);
  assign dump_addr  = ptr_r;
  assign dump_data  = data_r;

endmodule

// File: rtl/xregbank.sv
// xregbank -- architectural register storage with bit-sliced export and dump stream.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : write port and dump handshake (xregbank_if.slave)
//   regs_flat  : every register, bit i of register r at bit i*(1<<width)+r,
//                combinational from the storage flops
// Register 0 has no storage and always reads zero; writes to it are dropped.
module xregbank
  import xregbank_pkg::*;
#(
  parameter int width  = 5,
  parameter int height = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  xregbank_if.slave                    bus,
  output logic [(1<<width)*height-1:0] regs_flat
);

  localparam int nregs = 1 << width;

  logic              dump_busy_s;
  logic              dump_valid_s;
  logic [width-1:0]  dump_addr_s;
  logic [height-1:0] dump_data_s;

  for (genvar r = 0; r < nregs; r++) begin : g_reg
    if (r == 0) begin : g_zero
      for (genvar i = 0; i < height; i++) begin : g_bit
        assign regs_flat[i*nregs + r] = 1'b0;
      end
    end else begin : g_store
      localparam logic [width-1:0] addr_c = width'(r);
      logic [height-1:0] q_r;

      // Storage row for register r, written when the write port addresses it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_r <= zero_word[height-1:0];
        end else if (bus.we && (bus.waddr == addr_c)) begin
          q_r <= bus.wdata;
        end
      end

      for (genvar i = 0; i < height; i++) begin : g_bit
        assign regs_flat[i*nregs + r] = q_r[i];
      end
    end
  end

  xregbank_dump #(
    .width  (width),
    .height (height)
  ) u_dump (
    .clk        (clk),
    .rst_n      (rst_n),
    .regs_flat  (regs_flat),
    .we         (bus.we),
    .waddr      (bus.waddr),
    .wdata      (bus.wdata),
    .dump_start (bus.dump_start),
    .dump_ready (bus.dump_ready),
    .dump_busy  (dump_busy_s),
    .dump_valid (dump_valid_s),
    .dump_addr  (dump_addr_s),
    .dump_data  (dump_data_s)
  );

  assign bus.dump_busy  = dump_busy_s;
  assign bus.dump_valid = dump_valid_s;
  assign bus.dump_addr  = dump_addr_s;
  assign bus.dump_data  = dump_data_s;

endmodule
